// File: rtl/mlp_layer_sequencer.sv
// -----------------------------------------------------------------------------
// mlp_layer_sequencer
//
// Control FSM for a forward pass through an M-layer, N-neuron-per-layer MLP
// that time-shares one neuron and a dual-bank layer buffer. It streams the
// N-word input vector into the buffer's store bank, shifts it to the output
// bank, then for each layer starts the neuron once per output index, writes
// each result back to the store bank and shifts at layer end. After the final
// shift the last layer's outputs sit on the buffer's out_data.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   start, abort          begin a pass (IDLE only) / cancel back to IDLE
//   in_valid, in_data     input vector words, accepted while in_ready is high
//   in_ready              high in LOAD
//   neuron_start          one-cycle start pulse to the neuron
//   neuron_sel, layer_sel weight row / weight bank for the current computation
//   neuron_done/_result   neuron handshake, sampled only in WAIT
//   buf_write_enable/_address, buf_in_data, buf_shift   buffer initiator side
//   busy, done            pass in progress / one-cycle completion pulse
// -----------------------------------------------------------------------------
module mlp_layer_sequencer #(
    parameter int N     = 4,
    parameter int M     = 2,
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic                 neuron_start,
    output logic [$clog2(N):0]   neuron_sel,
    output logic [$clog2(M):0]   layer_sel,
    input  logic                 neuron_done,
    input  logic [WIDTH-1:0]     neuron_result,
    output logic                 buf_write_enable,
    output logic [$clog2(N):0]   buf_write_address,
    output logic [WIDTH-1:0]     buf_in_data,
    output logic                 buf_shift,
    output logic                 busy,
    output logic                 done
);

    localparam int NW = $clog2(N) + 1;
    localparam int MW = $clog2(M) + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_WRITE = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [NW-1:0]     load_cnt_q, load_cnt_d;
    logic [NW-1:0]     neuron_cnt_q, neuron_cnt_d;
    logic [MW-1:0]     layer_cnt_q, layer_cnt_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              in_ready_q, in_ready_d;
    logic              neuron_start_q, neuron_start_d;
    logic              shift_q, shift_d;
    logic              wr_q, wr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              load_wr_s;

    // The last load word must land before the SHIFT cycle that follows it,
    // so load writes go straight out in the acceptance cycle. An abort in
    // that same cycle suppresses the write so the buffer is left untouched.
    assign load_wr_s = (state_q == ST_LOAD) && in_valid && !abort;

    // Next-state, counter and registered-strobe logic.
    always_comb begin
        state_d      = state_q;
        load_cnt_d   = load_cnt_q;
        neuron_cnt_d = neuron_cnt_q;
        layer_cnt_d  = layer_cnt_q;
        result_d     = result_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_cnt_d   = '0;
                    neuron_cnt_d = '0;
                    layer_cnt_d  = '0;
                    state_d      = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    if (load_cnt_q == NW'(N - 1)) begin
                        load_cnt_d = '0;
                        state_d    = ST_SHIFT;
                    end else begin
                        load_cnt_d = load_cnt_q + NW'(1);
                    end
                end else begin
                    load_cnt_d = load_cnt_q;
                end
            end
            ST_SHIFT: begin
                // layer_cnt counts completed layers, so M means the pass is over.
                if (layer_cnt_q == MW'(M)) begin
                    state_d = ST_DONE;
                end else begin
                    neuron_cnt_d = '0;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (neuron_done) begin
                    result_d = neuron_result;
                    state_d  = ST_WRITE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WRITE: begin
                if (neuron_cnt_q == NW'(N - 1)) begin
                    layer_cnt_d = layer_cnt_q + MW'(1);
                    state_d     = ST_SHIFT;
                end else begin
                    neuron_cnt_d = neuron_cnt_q + NW'(1);
                    state_d      = ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            load_cnt_d   = '0;
            neuron_cnt_d = '0;
            layer_cnt_d  = '0;
            result_d     = '0;
        end else begin
            state_d = state_d;
        end

        // Strobes are decoded from the next state so they are registered and
        // line up exactly with the state they belong to.
        in_ready_d     = (state_d == ST_LOAD);
        neuron_start_d = (state_d == ST_ISSUE);
        shift_d        = (state_d == ST_SHIFT);
        wr_d           = (state_d == ST_WRITE);
        busy_d         = (state_d != ST_IDLE);
        done_d         = (state_d == ST_DONE);
    end

    // State, counter, result and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            load_cnt_q     <= '0;
            neuron_cnt_q   <= '0;
            layer_cnt_q    <= '0;
            result_q       <= '0;
            in_ready_q     <= 1'b0;
            neuron_start_q <= 1'b0;
            shift_q        <= 1'b0;
            wr_q           <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            load_cnt_q     <= load_cnt_d;
            neuron_cnt_q   <= neuron_cnt_d;
            layer_cnt_q    <= layer_cnt_d;
            result_q       <= result_d;
            in_ready_q     <= in_ready_d;
            neuron_start_q <= neuron_start_d;
            shift_q        <= shift_d;
            wr_q           <= wr_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign in_ready          = in_ready_q;
    assign neuron_start      = neuron_start_q;
    assign neuron_sel        = neuron_cnt_q;
    assign layer_sel         = layer_cnt_q;
    assign buf_shift         = shift_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign buf_write_enable  = load_wr_s | wr_q;
    assign buf_write_address = load_wr_s ? load_cnt_q : (wr_q ? neuron_cnt_q : '0);
    assign buf_in_data       = load_wr_s ? in_data    : (wr_q ? result_q     : '0);

endmodule
